alu_seq_unit: RTL

- Multi-cycle, handshaked responder wrapping the 16-bit ALU operation set.
- Accepts one operation request (ALUControl, A, B) over a valid/ready interface and executes it; single-cycle ops take 1 cycle and MUL uses a 16-iteration shift-add.
- Returns the result, high product word and Zero flag over a valid/ready response interface.
- Sits between the pipeline's issue stage and writeback, so the datapath can accept variable-latency ALU ops.

---
 rtl/alu_seq_unit_if.sv | 26 ++
 rtl/alu_seq_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between the issue stage and the sequential ALU.
// The master side issues operations and consumes results. The slave side is the ALU itself.
interface alu_seq_unit_if #(
  parameter int n = 16
);
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_ctrl;
  logic [n-1:0] req_a;
  logic [n-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [n-1:0] rsp_result;
  logic [n-1:0] rsp_hi;
  logic         rsp_zero;

  modport master (
    output req_valid, req_ctrl, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_hi, rsp_zero
  );

  modport slave (
    input  req_valid, req_ctrl, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_hi, rsp_zero
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential ALU responder. It accepts one op at a time and runs it.
// Single-cycle ops finish in EXEC. MUL uses a 16-step shift-add.
// The result is held in DONE until the consumer takes it.
module alu_seq_unit #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst,
  alu_seq_unit_if.slave bus
);
  localparam int sw = $clog2(n);
  localparam int cw = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      ctrl_reg;
  logic [n-1:0]    a_reg, b_reg;
  logic [2*n-1:0]  acc_reg, mcand_reg, acc_next;
  logic [sw-1:0]   cnt_reg;
  logic [n-1:0]    result_reg, hi_reg;
  logic            zero_reg;
  logic [n-1:0]    exec_res;
  logic            accept;

  logic [sw-1:0]   sh;
  logic [2*n-1:0]  rot_wide;
  logic [n-1:0]    cl_src, cl_pre;
  logic [cw-1:0]   lead_cnt;

  assign accept   = bus.req_valid && bus.req_ready;
  assign sh       = b_reg[sw-1:0];
  assign rot_wide = {a_reg, a_reg} >> sh;
  assign acc_next = acc_reg + (b_reg[0] ? mcand_reg : '0);

  // Leading-count helper. Bit gi is set when the top gi+1 bits of the source are all ones.
  // Counting zeros of A is the same as counting ones of ~A.
  assign cl_src = b_reg[0] ? ~a_reg : a_reg;
  for (genvar gi = 0; gi < n; gi++) begin : g_lead
    assign cl_pre[gi] = &cl_src[n-1 -: gi+1];
  end

  // Sum the prefix flags to get the leading-one count (0..n).
  always_comb begin
    lead_cnt = '0;
    for (int i = 0; i < n; i++) begin
      lead_cnt = lead_cnt + {{(cw-1){1'b0}}, cl_pre[i]};
    end
  end

  // Single-cycle result from the latched operands.
  always_comb begin
    exec_res = '0;
    case (ctrl_reg)
      4'd0:  exec_res = a_reg & b_reg;
      4'd1:  exec_res = a_reg | b_reg;
      4'd2:  exec_res = a_reg + b_reg;
      4'd3:  exec_res = ~(a_reg | b_reg);
      4'd4:  exec_res = a_reg ^ b_reg;
      4'd5:  exec_res = b_reg[0] ? a_reg : {{(n-8){a_reg[7]}}, a_reg[7:0]};
      4'd6:  exec_res = a_reg - b_reg;
      4'd7:  exec_res = {{(n-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
      4'd10: exec_res = a_reg << sh;
      4'd11: exec_res = {{(n-1){1'b0}}, ($signed(a_reg) > $signed(b_reg))};
      4'd12: exec_res = {{(n-cw){1'b0}}, lead_cnt};
      4'd13: exec_res = b_reg[n-1] ? rot_wide[n-1:0] : (a_reg >> sh);
      4'd14: exec_res = {{(n-1){1'b0}}, (a_reg < b_reg)};
      4'd15: exec_res = $signed(a_reg) >>> sh;
      default: exec_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. MUL steps until the counter reaches its last iteration.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (bus.req_ctrl == 4'd9) ? MUL : EXEC;
      EXEC: state_next = DONE;
      MUL:  if (cnt_reg == sw'(n - 1)) state_next = DONE;
      DONE: if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs. req_ready is forced low while reset is asserted.
  always_comb begin
    bus.req_ready  = (state_reg == IDLE) && !rst;
    bus.rsp_valid  = (state_reg == DONE);
    bus.rsp_result = result_reg;
    bus.rsp_hi     = hi_reg;
    bus.rsp_zero   = zero_reg;
  end

  // Datapath. It latches operands, steps the multiplier and registers the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg   <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      hi_reg     <= '0;
      zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          ctrl_reg  <= bus.req_ctrl;
          a_reg     <= bus.req_a;
          b_reg     <= bus.req_b;
          acc_reg   <= '0;
          mcand_reg <= {{n{1'b0}}, bus.req_a};
          cnt_reg   <= '0;
        end
        EXEC: begin
          result_reg <= exec_res;
          hi_reg     <= '0;
          zero_reg   <= (exec_res == '0);
        end
        MUL: begin
          // The multiplier bits are consumed LSB first by shifting b_reg right.
          acc_reg   <= acc_next;
          mcand_reg <= mcand_reg << 1;
          b_reg     <= b_reg >> 1;
          if (cnt_reg == sw'(n - 1)) begin
            cnt_reg    <= '0;
            result_reg <= acc_next[n-1:0];
            hi_reg     <= acc_next[2*n-1:n];
            zero_reg   <= (acc_next[n-1:0] == '0);
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
